// File: rtl/maze_tile_arbiter_if.sv
// Request/response, pellet-clear and maze RAM signals of the tile arbiter.
// The slave side is the arbiter; the master side is the surrounding game logic and RAM.
interface maze_tile_arbiter_if;
  logic [4:0]  req;
  logic [59:0] req_tile;
  logic [4:0]  gnt;
  logic        rsp_valid;
  logic [2:0]  rsp_id;
  logic [7:0]  rsp_info;
  logic        clr_req;
  logic [11:0] clr_tile;
  logic        clr_ack;
  logic        busy;
  logic [10:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [1:0]  mem_wdata;
  logic [1:0]  mem_rdata;

  modport master (
    output req, req_tile, clr_req, clr_tile, mem_rdata,
    input  gnt, rsp_valid, rsp_id, rsp_info, clr_ack, busy,
           mem_addr, mem_re, mem_we, mem_wdata
  );

  modport slave (
    input  req, req_tile, clr_req, clr_tile, mem_rdata,
    output gnt, rsp_valid, rsp_id, rsp_info, clr_ack, busy,
           mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/maze_tile_arbiter.sv
// Shares one maze RAM port between five actors: round-robin neighbour reads
// (up/left/down/right, tunnel wrap on x) interleaved with single-cycle pellet clears.
module maze_tile_arbiter #(
  parameter int MAZE_W = 28,
  parameter int MAZE_H = 31
) (
  input  logic               clk,
  input  logic               rst_n,
  maze_tile_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, DONE, CLR} state_e;

  localparam logic [5:0] W_LIM = 6'(MAZE_W);
  localparam logic [5:0] W_MAX = 6'(MAZE_W - 1);
  localparam logic [5:0] H_LIM = 6'(MAZE_H);
  localparam logic [5:0] H_MAX = 6'(MAZE_H - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  id_q, id_d;
  logic [11:0] tile_q, tile_d;
  logic        last_clr_q, last_clr_d;
  logic [5:0]  info_q, info_d;
  logic [4:0]  gnt_q, gnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [2:0]  rsp_id_q, rsp_id_d;
  logic [7:0]  rsp_info_q, rsp_info_d;

  logic [4:0][11:0] req_tiles;
  logic        found;
  logic [2:0]  win;
  logic [5:0]  x, y;
  logic        oob;
  logic [3:0]  frc;
  logic [4:0]  nx;
  logic [5:0]  ny;
  logic [1:0]  cap;
  logic [10:0] mem_addr;
  logic        mem_re, mem_we, clr_ack;

  assign req_tiles = bus.req_tile;
  assign x   = tile_q[11:6];
  assign y   = tile_q[5:0];
  assign oob = (x >= W_LIM) || (y >= H_LIM);
  // Slots that never touch RAM: maze edges in y, or a bogus latched tile.
  assign frc = {oob, oob | (y == H_MAX), oob, oob | (y == 6'd0)};

  function automatic logic [2:0] wrap5(input logic [3:0] v);
    return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
  endfunction

  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int k = 1; k <= 5; k++) begin
      if (!found && bus.req[wrap5({1'b0, ptr_q} + 4'(k))]) begin
        found = 1'b1;
        win   = wrap5({1'b0, ptr_q} + 4'(k));
      end
    end
  end

  always_comb begin
    nx = x[4:0];
    ny = y;
    case (cnt_q)
      2'd0:    ny = y - 6'd1;
      2'd1:    nx = (x == 6'd0) ? W_MAX[4:0] : x[4:0] - 5'd1;
      2'd2:    ny = y + 6'd1;
      default: nx = (x == W_MAX) ? 5'd0 : x[4:0] + 5'd1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    tile_d      = tile_q;
    last_clr_d  = last_clr_q;
    info_d      = info_q;
    gnt_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = '0;
    rsp_info_d  = '0;
    mem_addr    = '0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    clr_ack     = 1'b0;
    // RAM data lags the strobe by a cycle, so each cycle retires the previous slot.
    cap         = frc[cnt_q - 2'd1] ? 2'b11 : bus.mem_rdata;
    case (state_q)
      IDLE: begin
        if (bus.clr_req && !last_clr_q) begin
          state_d = CLR;
          tile_d  = bus.clr_tile;
        end else if (found) begin
          state_d    = RD;
          cnt_d      = 2'd0;
          ptr_d      = win;
          id_d       = win;
          tile_d     = req_tiles[win];
          gnt_d[win] = 1'b1;
          last_clr_d = 1'b0;
        end else if (bus.clr_req) begin
          state_d = CLR;
          tile_d  = bus.clr_tile;
        end
      end
      RD: begin
        mem_re = !frc[cnt_q];
        if (!frc[cnt_q]) mem_addr = {ny, nx};
        case (cnt_q)
          2'd1:    info_d[1:0] = cap;
          2'd2:    info_d[3:2] = cap;
          2'd3:    info_d[5:4] = cap;
          default: ;
        endcase
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_info_d  = {frc[3] ? 2'b11 : bus.mem_rdata, info_q};
        cnt_d       = 2'd0;
        state_d     = IDLE;
      end
      default: begin
        clr_ack    = 1'b1;
        mem_addr   = {y, x[4:0]};
        mem_we     = !oob;
        last_clr_d = 1'b1;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= 3'd4;
      id_q        <= '0;
      tile_q      <= '0;
      last_clr_q  <= 1'b0;
      info_q      <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_info_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      tile_q      <= tile_d;
      last_clr_q  <= last_clr_d;
      info_q      <= info_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_info_q  <= rsp_info_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_info  = rsp_info_q;
  assign bus.clr_ack   = clr_ack;
  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_re    = mem_re;
  assign bus.mem_we    = mem_we;
  assign bus.mem_wdata = 2'b00;
endmodule

// File: doc/maze_tile_arbiter.md
MAZE_TILE_ARBITER -- requirements
Module: maze_tile_arbiter

Interface
REQ-001 Parameter: MAZE_W, 28, maze width in tiles.
REQ-002 Parameter: MAZE_H, 31, maze height in tiles.
REQ-003 Port: clk  in  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: req  in  5  per-requester read request, level: 0 pacman, 1 blinky, 2 pinky, 3 inky, 4 clyde.
REQ-006 Port: req_tile  in  60  requester i tile at [12i+11:12i], {x[5:0], y[5:0]}.
REQ-007 Port: gnt  out  5  one-hot, one-cycle grant pulse.
REQ-008 Port: rsp_valid  out  1  one-cycle response pulse.
REQ-009 Port: rsp_id  out  3  index of the requester being answered.
REQ-010 Port: rsp_info  out  8  neighbour codes: [1:0] up, [3:2] left, [5:4] down, [7:6] right.
REQ-011 Port: clr_req  in  1  pellet-clear request, level.
REQ-012 Port: clr_tile  in  12  tile to clear, {x, y}.
REQ-013 Port: clr_ack  out  1  one-cycle clear-done pulse.
REQ-014 Port: busy  out  1  high whenever the state is not IDLE.
REQ-015 Port: mem_addr  out  11  maze RAM address, {y[5:0], x[4:0]}.
REQ-016 Port: mem_re / mem_we  out  1 each  RAM read / write strobes.
REQ-017 Port: mem_wdata  out  2  RAM write data.
REQ-018 Port: mem_rdata  in  2  RAM read data, valid the cycle after mem_re.

Function
REQ-019 Tile codes SHALL be: 00 empty, 01 pellet, 10 power pellet, 11 wall.
REQ-020 States SHALL be: IDLE, RD (4 cycles, cnt 0..3), DONE, CLR.
REQ-021 In IDLE, clr_req high with last_was_clr=0 SHALL select CLR; otherwise any req high SHALL select a read, and otherwise clr_req high SHALL select CLR.
REQ-022 Read winner SHALL be the first asserted req scanning from (ptr+1) mod 5 upward with wrap; ptr SHALL update to the winner.
REQ-023 On a read decision in cycle T, the arbiter SHALL latch the winner index and tile, assert gnt[winner] in T+1 only, and enter RD with cnt=0 in T+1.
REQ-024 RD cycle cnt SHALL drive the neighbour address for cnt 0..3 = up, left, down, right, with mem_re=1.
REQ-025 Neighbour rules: up (x, y-1); left (x-1, y); down (x, y+1); right (x+1, y).
REQ-026 Left of x=0 SHALL wrap to MAZE_W-1, and right of x=MAZE_W-1 SHALL wrap to 0 (tunnel).
REQ-027 Up from y=0 and down from y=MAZE_H-1 SHALL be forced to 11 with mem_re=0 in that slot.
REQ-028 A latched x>=MAZE_W or y>=MAZE_H SHALL force all four slots to 11 with mem_re=0 throughout.
REQ-029 Timing SHALL be fixed regardless of forcing.
REQ-030 mem_rdata SHALL be captured one cycle after each mem_re slot (T+2..T+5); T+5 SHALL be the DONE state.
REQ-031 rsp_valid, rsp_id and rsp_info SHALL be registered and visible in T+6 for exactly one cycle, with state IDLE in T+6.
REQ-032 A read request SHALL have a minimum turnaround of 6 cycles, decision to decision.
REQ-033 Requester i SHALL hold req[i] and req_tile[i] stable until gnt[i].
REQ-034 req[i] dropped before its grant SHALL never be granted.
REQ-035 req[i] still high after its response SHALL re-arbitrate normally.
REQ-036 CLR SHALL last one cycle, asserting mem_we=1, mem_wdata=00, mem_addr of clr_tile and clr_ack=1, then return to IDLE with last_was_clr=1.
REQ-037 Any read decision SHALL set last_was_clr=0.
REQ-038 A clr_tile that is out of range SHALL still pulse clr_ack with mem_we=0.
REQ-039 Simultaneous clr_req and req: clear first, then one read, alternating while both persist.
REQ-040 A pending request SHALL never be starved.
REQ-041 mem_re and mem_we SHALL never be high together.

Reset
REQ-042 rst_n low SHALL immediately set the state to IDLE, ptr=4, last_was_clr=0, cnt=0, and every output to 0, including rsp_info and mem_addr.
REQ-043 rst_n asserted mid-read SHALL discard the partial response, with no rsp_valid afterwards.
REQ-044 The first decision after rst_n rises SHALL be no earlier than the first rising edge with rst_n high.

Verification
REQ-045 Scenario: req=00001, pacman tile (5,5), RAM (5,4)=01, (4,5)=11, (5,6)=00, (6,5)=10 -> gnt=00001 at T+1; rsp_valid at T+6, rsp_id=0, rsp_info=8'b10_00_11_01.
REQ-046 Scenario: req=11111 held after reset -> grant order 0,1,2,3,4,0, with decisions 6 cycles apart.
REQ-047 Scenario: tile (0,0) -> up forced 11 with mem_re=0; left reads address {y=0, x=27}.
REQ-048 Scenario: tile (27,30) -> right reads x=0; down is forced 11.
REQ-049 Scenario: clr_req and req=00100 both held -> CLR (clr_ack, mem_we, wdata 00), then read for 2, then CLR again.
REQ-050 Scenario: rst_n pulsed low at T+3 of a read -> outputs 0 at once, no rsp_valid, and the next grant goes to the lowest asserted index.
